// File: rtl/mm_xcvr_rst_seq_pkg.sv
// mm_xcvr_rst_seq_pkg: FPGA target/family decode, per-family transceiver reset timing and sequencer types.
package mm_xcvr_rst_seq_pkg;

    typedef enum logic [2:0] {
        MM_FPGA_XILINX_XC7K325T_2,
        MM_FPGA_XILINX_XCKU040_2,
        MM_FPGA_XILINX_XCVU9P_22L,
        MM_FPGA_INTEL_10AX115_2,
        MM_FPGA_MICROCHIP_M2GL090,
        MM_FPGA_LATTICE_LFE5U_85F
    } mm_fpga_target_t;

    typedef enum logic [2:0] {
        MM_FAMILY_7SERIES,
        MM_FAMILY_ULTRASCALE,
        MM_FAMILY_ULTRASCALEP,
        MM_FAMILY_ARRIA10,
        MM_FAMILY_IGLOO2,
        MM_FAMILY_ECP5
    } mm_fpga_family_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PLL_RST,
        ST_WAIT_LOCK,
        ST_DP_RST,
        ST_WAIT_DONE,
        ST_RETRY,
        ST_DONE,
        ST_FAULT
    } mm_xcvr_rst_state_t;

    typedef struct packed {
        logic [31:0] pll_us;
        logic [31:0] lock_to_us;
        logic [31:0] dp_us;
        logic [31:0] done_to_us;
    } mm_xcvr_rst_timing_t;

    typedef struct packed {
        logic pll_rst;
        logic datapath_rst;
        logic ready;
        logic fault;
    } mm_xcvr_rst_outs_t;

    function automatic mm_fpga_family_t mm_get_fpga_family(mm_fpga_target_t target);
        case (target)
            MM_FPGA_XILINX_XC7K325T_2: mm_get_fpga_family = MM_FAMILY_7SERIES;
            MM_FPGA_XILINX_XCKU040_2:  mm_get_fpga_family = MM_FAMILY_ULTRASCALE;
            MM_FPGA_XILINX_XCVU9P_22L: mm_get_fpga_family = MM_FAMILY_ULTRASCALEP;
            MM_FPGA_INTEL_10AX115_2:   mm_get_fpga_family = MM_FAMILY_ARRIA10;
            MM_FPGA_MICROCHIP_M2GL090: mm_get_fpga_family = MM_FAMILY_IGLOO2;
            default:                   mm_get_fpga_family = MM_FAMILY_ECP5;
        endcase
    endfunction

    function automatic mm_xcvr_rst_timing_t mm_get_xcvr_rst_timing(mm_fpga_family_t family);
        case (family)
            MM_FAMILY_7SERIES, MM_FAMILY_ULTRASCALE, MM_FAMILY_ULTRASCALEP:
                mm_get_xcvr_rst_timing = '{32'd1, 32'd500, 32'd1, 32'd1000};
            MM_FAMILY_ARRIA10:
                mm_get_xcvr_rst_timing = '{32'd2, 32'd1000, 32'd2, 32'd1000};
            MM_FAMILY_IGLOO2:
                mm_get_xcvr_rst_timing = '{32'd4, 32'd2000, 32'd4, 32'd1000};
            default: begin
                mm_get_xcvr_rst_timing = '0;
                $error("mm_get_xcvr_rst_timing: no reset timing for FPGA family %0d", family);
            end
        endcase
    endfunction

    function automatic mm_xcvr_rst_outs_t mm_xcvr_rst_outs(mm_xcvr_rst_state_t s);
        mm_xcvr_rst_outs = '{
            pll_rst:      s inside {ST_IDLE, ST_PLL_RST, ST_RETRY, ST_FAULT},
            datapath_rst: !(s inside {ST_WAIT_DONE, ST_DONE}),
            ready:        s == ST_DONE,
            fault:        s == ST_FAULT
        };
    endfunction

endpackage

// File: rtl/mm_rst_timer.sv
// mm_rst_timer: loadable down-counter; expired is already valid in the load cycle,
// so loading N-1 makes expired fire on the Nth cycle after the load.
module mm_rst_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expired
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= value == '0 ? '0 : value - W'(1);
        else if (cnt != '0)
            cnt <= cnt - W'(1);
    end

    assign expired = load ? value == '0 : cnt == '0;

endmodule

// File: rtl/mm_xcvr_rst_seq.sv
// mm_xcvr_rst_seq: family-aware PLL/datapath reset sequencer for one transceiver quad with timeout retries.
// Define MM_XCVR_RST_SEQ_LOCK_MONITOR_EN to restart the sequence when PLL lock drops while ready.
module mm_xcvr_rst_seq
    import mm_xcvr_rst_seq_pkg::*;
#(
    parameter mm_fpga_target_t FPGA_TARGET        = MM_FPGA_XILINX_XCVU9P_22L,
    parameter int              CLK_FREQ_MHZ       = 100,
    parameter int              MAX_RETRIES        = 3,
    parameter int              LOCK_STABLE_CYCLES = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic                             pll_lock,
    input  logic                             reset_done,
    output logic                             pll_rst,
    output logic                             datapath_rst,
    output logic                             ready,
    output logic                             fault,
    output logic [$clog2(MAX_RETRIES+1)-1:0] retry_cnt
);
    localparam mm_xcvr_rst_timing_t TIMING = mm_get_xcvr_rst_timing(mm_get_fpga_family(FPGA_TARGET));
    localparam int PLL_CYC  = CLK_FREQ_MHZ * int'(TIMING.pll_us);
    localparam int LOCK_CYC = CLK_FREQ_MHZ * int'(TIMING.lock_to_us);
    localparam int DP_CYC   = CLK_FREQ_MHZ * int'(TIMING.dp_us);
    localparam int DONE_CYC = CLK_FREQ_MHZ * int'(TIMING.done_to_us);
    localparam int MAX_PD   = PLL_CYC > DP_CYC ? PLL_CYC : DP_CYC;
    localparam int MAX_TO   = LOCK_CYC > DONE_CYC ? LOCK_CYC : DONE_CYC;
    localparam int CW       = $clog2(MAX_PD > MAX_TO ? MAX_PD : MAX_TO);
    localparam int RW       = $clog2(MAX_RETRIES + 1);
    localparam int LW       = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_STABLE_CYCLES - 1);

    if (PLL_CYC <= 0) begin : g_no_timing
        $error("mm_xcvr_rst_seq: FPGA_TARGET %0d has no reset timing entry", FPGA_TARGET);
    end

    mm_xcvr_rst_state_t state, prev_state;
    mm_xcvr_rst_outs_t  outs;
    logic [LW-1:0]      lock_cnt;
    logic [CW-1:0]      tmr_value;
    logic               tmr_exp;

    assign {pll_rst, datapath_rst, ready, fault} = outs;

    // The shared timer reloads with the new state's limit on the first cycle of every state.
    assign tmr_value = state == ST_PLL_RST   ? CW'(PLL_CYC - 1)  :
                       state == ST_WAIT_LOCK ? CW'(LOCK_CYC - 1) :
                       state == ST_DP_RST    ? CW'(DP_CYC - 1)   : CW'(DONE_CYC - 1);

    mm_rst_timer #(.W(CW)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (state != prev_state),
        .value   (tmr_value),
        .expired (tmr_exp)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            prev_state <= ST_IDLE;
            outs       <= mm_xcvr_rst_outs(ST_IDLE);
            retry_cnt  <= '0;
            lock_cnt   <= '0;
        end else begin
            prev_state <= state;
            case (state)
                ST_IDLE: if (start) begin
                    state     <= ST_PLL_RST;
                    outs      <= mm_xcvr_rst_outs(ST_PLL_RST);
                    retry_cnt <= '0;
                end
                ST_PLL_RST: begin
                    lock_cnt <= '0;
                    if (tmr_exp) begin
                        state <= ST_WAIT_LOCK;
                        outs  <= mm_xcvr_rst_outs(ST_WAIT_LOCK);
                    end
                end
                ST_WAIT_LOCK: begin
                    lock_cnt <= pll_lock ? lock_cnt + LW'(1) : '0;
                    if (pll_lock && lock_cnt == LOCK_LAST) begin
                        state <= ST_DP_RST;
                        outs  <= mm_xcvr_rst_outs(ST_DP_RST);
                    end else if (tmr_exp) begin
                        state <= ST_RETRY;
                        outs  <= mm_xcvr_rst_outs(ST_RETRY);
                    end
                end
                ST_DP_RST: if (tmr_exp) begin
                    state <= ST_WAIT_DONE;
                    outs  <= mm_xcvr_rst_outs(ST_WAIT_DONE);
                end
                ST_WAIT_DONE: if (reset_done) begin
                    state <= ST_DONE;
                    outs  <= mm_xcvr_rst_outs(ST_DONE);
                end else if (tmr_exp) begin
                    state <= ST_RETRY;
                    outs  <= mm_xcvr_rst_outs(ST_RETRY);
                end
                ST_RETRY: if (retry_cnt < RETRY_MAX) begin
                    state     <= ST_PLL_RST;
                    outs      <= mm_xcvr_rst_outs(ST_PLL_RST);
                    retry_cnt <= retry_cnt + RW'(1);
                end else begin
                    state <= ST_FAULT;
                    outs  <= mm_xcvr_rst_outs(ST_FAULT);
                end
`ifdef MM_XCVR_RST_SEQ_LOCK_MONITOR_EN
                ST_DONE: if (!start) begin
                    state <= ST_IDLE;
                    outs  <= mm_xcvr_rst_outs(ST_IDLE);
                end else if (!pll_lock) begin
                    state     <= ST_PLL_RST;
                    outs      <= mm_xcvr_rst_outs(ST_PLL_RST);
                    retry_cnt <= '0;
                end
`else
                ST_DONE: if (!start) begin
                    state <= ST_IDLE;
                    outs  <= mm_xcvr_rst_outs(ST_IDLE);
                end
`endif
                ST_FAULT: if (!start) begin
                    state <= ST_IDLE;
                    outs  <= mm_xcvr_rst_outs(ST_IDLE);
                end
                default: begin
                    state <= ST_IDLE;
                    outs  <= mm_xcvr_rst_outs(ST_IDLE);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mm_xcvr_rst_seq.sv
// tb_mm_xcvr_rst_seq: directed checks of the reset sequencer on a 7-series and an IGLOO2 target at 10 MHz.
// Lock-monitor expectations follow MM_XCVR_RST_SEQ_LOCK_MONITOR_EN.
module tb_mm_xcvr_rst_seq;
    import mm_xcvr_rst_seq_pkg::*;

    localparam int PLL_LO = 0, DP_LO = 1, RDY_HI = 2, PLL_HI = 3, IG_PLL_LO = 4, IG_DP_LO = 5;

    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, pll_lock = 1'b0, reset_done = 1'b0;
    logic       pll_rst, datapath_rst, ready, fault;
    logic [1:0] retry_cnt;
    logic       ig_start = 1'b0, ig_lock = 1'b0, ig_done = 1'b0;
    logic       ig_pll_rst, ig_dp_rst, ig_ready, ig_fault;
    logic [1:0] ig_retry_cnt;
    int         checks = 0, errors = 0, n;

    always #5 clk = ~clk;

    mm_xcvr_rst_seq #(.FPGA_TARGET(MM_FPGA_XILINX_XC7K325T_2), .CLK_FREQ_MHZ(10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pll_lock(pll_lock), .reset_done(reset_done),
        .pll_rst(pll_rst), .datapath_rst(datapath_rst), .ready(ready), .fault(fault), .retry_cnt(retry_cnt)
    );

    mm_xcvr_rst_seq #(.FPGA_TARGET(MM_FPGA_MICROCHIP_M2GL090), .CLK_FREQ_MHZ(10)) dut_ig (
        .clk(clk), .rst_n(rst_n), .start(ig_start), .pll_lock(ig_lock), .reset_done(ig_done),
        .pll_rst(ig_pll_rst), .datapath_rst(ig_dp_rst), .ready(ig_ready), .fault(ig_fault), .retry_cnt(ig_retry_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int k);
        repeat (k) tick();
    endtask

    function automatic logic cond(input int sel);
        case (sel)
            PLL_LO:    return !pll_rst;
            DP_LO:     return !datapath_rst;
            RDY_HI:    return ready;
            PLL_HI:    return pll_rst;
            IG_PLL_LO: return !ig_pll_rst;
            IG_DP_LO:  return !ig_dp_rst;
            default:   return fault;
        endcase
    endfunction

    // Ticks until the selected condition holds; returns lim if it never does.
    task automatic run_until(input int sel, input int lim, output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!cond(sel) && cnt < lim);
    endtask

    initial begin
        ticks(5);
        check("rst_pll_rst", pll_rst, 1);
        check("rst_datapath_rst", datapath_rst, 1);
        check("rst_ready", ready, 0);
        check("rst_fault", fault, 0);
        check("rst_retry_cnt", retry_cnt, 0);
        check("rst_ig_pll_rst", ig_pll_rst, 1);
        rst_n = 1'b1;
        tick();

        start = 1'b1;
        run_until(PLL_LO, 100, n);
        check("nom_start_to_pll_fall", n, 11);
        ticks(100);
        check("nom_wait_lock_pll_rst", pll_rst, 0);
        check("nom_wait_lock_dp_rst", datapath_rst, 1);
        pll_lock = 1'b1;
        run_until(DP_LO, 100, n);
        check("nom_lock_to_dp_fall", n, 18);
        ticks(50);
        check("nom_wait_done_ready", ready, 0);
        reset_done = 1'b1;
        run_until(RDY_HI, 20, n);
        check("nom_done_to_ready", n, 1);
        check("nom_done_pll_rst", pll_rst, 0);
        check("nom_done_dp_rst", datapath_rst, 0);
        check("nom_done_retry_cnt", retry_cnt, 0);
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
`ifdef MM_XCVR_RST_SEQ_LOCK_MONITOR_EN
        check("mon_ready_drop", ready, 0);
        check("mon_pll_rst", pll_rst, 1);
        check("mon_retry_cnt", retry_cnt, 0);
        run_until(PLL_LO, 100, n);
        check("mon_pll_pulse", n, 10);
`else
        check("nomon_ready_held", ready, 1);
        check("nomon_pll_rst", pll_rst, 0);
`endif
        rst_n = 1'b0;
        start = 1'b0;
        tick();
        check("midrst_pll_rst", pll_rst, 1);
        check("midrst_dp_rst", datapath_rst, 1);
        check("midrst_ready", ready, 0);
        check("midrst_retry_cnt", retry_cnt, 0);
        rst_n = 1'b1;
        pll_lock = 1'b0;
        reset_done = 1'b0;
        tick();

        start = 1'b1;
        run_until(PLL_LO, 100, n);
        check("glitch_start_to_pll_fall", n, 11);
        start = 1'b0;
        pll_lock = 1'b1;
        ticks(5);
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        run_until(DP_LO, 100, n);
        check("glitch_lock_to_dp_fall", n, 18);
        reset_done = 1'b1;
        run_until(RDY_HI, 20, n);
        check("glitch_done_to_ready", n, 1);
        tick();
        check("glitch_idle_ready", ready, 0);
        check("glitch_idle_pll_rst", pll_rst, 1);
        check("glitch_idle_dp_rst", datapath_rst, 1);
        reset_done = 1'b0;
        pll_lock = 1'b0;

        start = 1'b1;
        run_until(PLL_LO, 100, n);
        check("retry_start_to_pll_fall", n, 11);
        for (int i = 0; i < 4; i++) begin
            run_until(PLL_HI, 6000, n);
            check("retry_lock_timeout", n, 5000);
            check("retry_cnt_in_retry", retry_cnt, i);
            if (i < 3) begin
                run_until(PLL_LO, 100, n);
                check("retry_pll_pulse", n, 11);
                check("retry_cnt_after", retry_cnt, i + 1);
            end
        end
        tick();
        check("fault_set", fault, 1);
        check("fault_retry_cnt", retry_cnt, 3);
        check("fault_pll_rst", pll_rst, 1);
        check("fault_dp_rst", datapath_rst, 1);
        ticks(3);
        check("fault_held", fault, 1);
        start = 1'b0;
        tick();
        check("fault_to_idle", fault, 0);
        check("fault_idle_pll_rst", pll_rst, 1);
        start = 1'b1;
        tick();
        check("rerun_retry_cnt_clear", retry_cnt, 0);
        start = 1'b0;

        ig_start = 1'b1;
        run_until(IG_PLL_LO, 100, n);
        check("ig_start_to_pll_fall", n, 41);
        ticks(19992);
        check("ig_no_early_timeout", ig_pll_rst, 0);
        ig_lock = 1'b1;
        run_until(IG_DP_LO, 100, n);
        check("ig_lock_wins_dp_fall", n, 48);
        check("ig_pll_rst_low", ig_pll_rst, 0);
        check("ig_retry_cnt", ig_retry_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mm_xcvr_rst_seq.md
# mm_xcvr_rst_seq

Family-aware transceiver reset sequencer. It sits directly downstream of the FPGA spec package: the `FPGA_TARGET` parameter is resolved to a family at elaboration time, and the family selects the reset pulse widths and lock/done timeouts. It drives one transceiver quad's PLL reset and datapath reset, retries on timeout, and reports `ready` or `fault` to the link-bring-up logic.

## Interface
- `FPGA_TARGET`, default `MM_FPGA_XILINX_XCVU9P_22L`, is an `mm_fpga_target_t` that is resolved through `mm_get_fpga_family`. A target with no timing entry is an elaboration `$error`.
- `CLK_FREQ_MHZ`, default 100, is an integer ≥ 1. All µs timings are multiplied by this value to give cycle counts.
- `MAX_RETRIES`, default 3, is the number of timeout retries allowed before `fault`.
- `LOCK_STABLE_CYCLES`, default 8, is the number of consecutive cycles `pll_lock` must be high to count as locked.

Ports:
- `clk`, in, 1: single clock. Reset is synchronous and active-low.
- `rst_n`, in, 1: synchronous, active-low reset.
- `start`, in, 1: level-sampled request to run the sequence.
- `pll_lock`, in, 1: PLL lock from the transceiver, already synchronous to `clk`.
- `reset_done`, in, 1: transceiver datapath reset-done, already synchronous to `clk`.
- `pll_rst`, out, 1: PLL reset, active-high.
- `datapath_rst`, out, 1: datapath reset, active-high.
- `ready`, out, 1: sequence completed.
- `fault`, out, 1: retries exhausted.
- `retry_cnt`, out, `$clog2(MAX_RETRIES+1)`: retries consumed in the current run.

## Operation
Family timing, in µs (PLL pulse / lock timeout / datapath pulse / done timeout):
- 7SERIES: 1 / 500 / 1 / 1000
- ARRIA10: 2 / 1000 / 2 / 1000
- ULTRASCALE and ULTRASCALEP: 1 / 500 / 1 / 1000
- IGLOO2: 4 / 2000 / 4 / 1000

Cycles = µs × `CLK_FREQ_MHZ`. The counter width is `$clog2` of the largest count.

States:
- **IDLE**: `pll_rst`=1, `datapath_rst`=1. `start`=1 → PLL_RST, clearing `retry_cnt`.
- **PLL_RST**: `pll_rst`=1 for exactly the PLL-pulse cycles → WAIT_LOCK.
- **WAIT_LOCK**: `pll_rst`=0, `datapath_rst`=1.
  - Lock held `LOCK_STABLE_CYCLES` consecutive cycles → DP_RST. Any low cycle restarts the stability count.
  - Timeout → RETRY.
- **DP_RST**: `datapath_rst`=1 for exactly the datapath-pulse cycles → WAIT_DONE.
- **WAIT_DONE**: `datapath_rst`=0.
  - `reset_done`=1 → DONE.
  - Timeout → RETRY.
- **RETRY** (one cycle): both resets asserted. If `retry_cnt` < `MAX_RETRIES`, increment it and go to PLL_RST; otherwise go to FAULT.
- **DONE**: `ready`=1, both resets 0. `start` falling to 0 → IDLE.
- **FAULT**: `fault`=1, both resets asserted. `start` falling to 0 → IDLE; a new rising run then begins from IDLE.

Rules:
- `start` is ignored in every state other than IDLE, DONE and FAULT. Dropping `start` mid-sequence does not abort the run.
- In WAIT_LOCK, when the timeout expiry and lock qualification occur on the same cycle, lock wins.
- In WAIT_DONE, when the timeout expiry and `reset_done` occur on the same cycle, done wins.

## Timing
- Reset values: `pll_rst`=1, `datapath_rst`=1, `ready`=0, `fault`=0, `retry_cnt`=0, state IDLE.
- `rst_n` low mid-sequence returns the block to these values on the next edge.
- All outputs are registered. Each one reflects the state entered on that edge.
- Latency from `start` to `pll_rst` deassertion = 1 + PLL-pulse cycles.
- `ready` rises 1 cycle after the qualifying `reset_done` sample.
- The timeout counter reloads on every state entry. The timeout fires when the count reaches the limit; the state exits at that edge.

## Configuration
- `MM_XCVR_RST_SEQ_LOCK_MONITOR_EN` defined: in DONE, any cycle with `pll_lock`=0 → next cycle `ready`=0 and state PLL_RST, with `retry_cnt` cleared.
- Macro undefined: `pll_lock` is ignored outside WAIT_LOCK.

## Structure
- Package `mm_xcvr_rst_seq_pkg` holds:
  - `mm_xcvr_rst_state_t`, the state enum.
  - `mm_xcvr_rst_timing_t`, a struct of four µs fields.
  - `mm_get_xcvr_rst_timing(mm_fpga_family_t)`, which calls `$error` for an unknown family.
- Sub-module `mm_rst_timer` is a loadable down-counter with `load`, `value`, and `expired` signals. The sequencer uses one shared instance.

## Test plan
All scenarios use `CLK_FREQ_MHZ`=10.
- **Reset**: hold `rst_n`=0 for 5 cycles → `pll_rst`=1, `datapath_rst`=1, `ready`=0, `fault`=0, `retry_cnt`=0.
- **Nominal 7SERIES run**: `start`=1, lock after 100 cycles, `reset_done` after 50 cycles → `pll_rst` high for exactly 10 cycles, `datapath_rst` high for exactly 10 cycles, `ready`=1 one cycle after `reset_done`.
- **Lock glitch**: lock high for 5 cycles, low for 1, then high → DP_RST entered only after 8 clean cycles.
- **Retries exhausted**: lock never asserted, `MAX_RETRIES`=3 → 4 PLL pulses, each 5000 cycles apart; `retry_cnt`=3; then `fault`=1. Dropping `start` → IDLE.
- **IGLOO2 target**: `pll_rst` pulse is exactly 40 cycles. Lock timeout and lock arriving on the same cycle → DP_RST, no retry.
- **Lock monitor (macro defined)**: in DONE, drop `pll_lock` for 1 cycle → `ready`=0 the next cycle, a new 10-cycle `pll_rst` pulse, and `retry_cnt`=0.
